// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches with credit-based
// flow control, buffers responses in a small FIFO, and flushes on taken-branch redirects.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ir,
  output logic [31:0]              out_npc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = PW + 2;

  logic [AW-1:0] pc_q;
  logic          halted_q;
  logic          rsp_vld_p1;
  logic [AW-1:0] rsp_npc_p1;

  logic [31:0]   ir_mem  [DEPTH];
  logic [AW-1:0] npc_mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic empty;
  logic credit_ok;
  logic push;
  logic pop;

  // ---- stage p0: request issue (credit counts queued entries plus the response in flight)
  always_comb begin
    empty     = (count_q == '0);
    credit_ok = ({1'b0, count_q} + SW'(rsp_vld_p1)) < SW'(DEPTH);
    imem_req  = rst_n && !halt && !redirect_valid && !halted_q && credit_ok;
    imem_addr = pc_q;
  end

  // ---- stage p1: response capture; a redirect kills the arriving response and any pop
  always_comb begin
    push = rst_n && rsp_vld_p1 && !redirect_valid;
    pop  = rst_n && !redirect_valid && !empty && out_ready;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      pc_q       <= '0;
      halted_q   <= 1'b0;
      rsp_vld_p1 <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      if (halt) begin
        halted_q <= 1'b1;
      end
      rsp_vld_p1 <= imem_req;

      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (imem_req) begin
        pc_q <= pc_q + 1'b1;
      end

      if (redirect_valid) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          tail_q <= tail_q + 1'b1;
        end
        if (pop) begin
          head_q <= head_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by the control state.
  always_ff @(posedge clk1) begin
    if (imem_req) begin
      rsp_npc_p1 <= imem_addr + 1'b1;
    end
    if (push) begin
      ir_mem[tail_q]  <= imem_rdata;
      npc_mem[tail_q] <= rsp_npc_p1;
    end
  end

  // ---- stage p2: head presentation to decode
  always_comb begin
    out_valid = rst_n && !empty;
    count     = rst_n ? count_q : '0;
    out_ir    = out_valid ? ir_mem[head_q] : 32'd0;
    out_npc   = out_valid ? 32'(npc_mem[head_q]) : 32'd0;
  end

endmodule
